// File: rtl/duty_meter_pkg.sv
// Shared types for the PWM duty meter: measurement FSM states, divider states
// and the IIR averaging shift.
package duty_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} meter_state_e;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;
  localparam int AVG_SHIFT = 3;
endpackage

// File: rtl/pwm_duty_meter_if.sv
// Duty meter signal bundle: master drives enable and the PWM clock, slave
// (the meter) returns the duty/period results and status pulses.
interface pwm_duty_meter_if #(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 10
);
  logic              en;
  logic              pwm_in;
  logic [DUTY_W-1:0] duty_out;
  logic [CNT_W-1:0]  period_out;
  logic              duty_valid;
  logic              overflow;
  logic              overrun;

  modport master (output en, pwm_in,
                  input  duty_out, period_out, duty_valid, overflow, overrun);
  modport slave  (input  en, pwm_in,
                  output duty_out, period_out, duty_valid, overflow, overrun);
endinterface

// File: rtl/duty_divider.sv
// Serial restoring divider: quot = floor(num * 2^DUTY_W / den), one bit per cycle
// after a load cycle; stays busy for one extra cycle while the result is published.
module duty_divider
  import duty_meter_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int DUTY_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_num,
  input  logic [CNT_W-1:0]  i_den,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_quot
);
  localparam int CW = $clog2(DUTY_W + 1);

  div_state_e        r_state;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_den;
  logic [DUTY_W-2:0] r_quot;
  logic [CW-1:0]     r_cnt;
  logic              r_sat;

  logic [CNT_W:0]    w_shift;
  logic              w_ge;
  logic [CNT_W-1:0]  w_rem_nxt;
  logic [DUTY_W-1:0] w_quot_nxt;
  logic              w_last;

  assign w_shift    = {r_rem, 1'b0};
  assign w_ge       = w_shift >= {1'b0, r_den};
  assign w_rem_nxt  = w_ge ? CNT_W'(w_shift - {1'b0, r_den}) : w_shift[CNT_W-1:0];
  assign w_quot_nxt = {r_quot, w_ge};
  assign w_last     = r_cnt == CW'(DUTY_W - 1);

  assign o_busy = r_state != DIV_IDLE;
  assign o_done = (r_state == DIV_RUN) && w_last;
  // num >= den means a 100% duty, which does not fit in DUTY_W bits
  assign o_quot = r_sat ? '1 : w_quot_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
      r_rem   <= '0;
      r_den   <= '0;
      r_quot  <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else if (i_abort) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: if (i_start) begin
          r_state <= DIV_RUN;
          r_rem   <= i_num;
          r_den   <= i_den;
          r_quot  <= '0;
          r_cnt   <= '0;
          r_sat   <= i_num >= i_den;
        end
        DIV_RUN: begin
          r_rem  <= w_rem_nxt;
          r_quot <= w_quot_nxt[DUTY_W-2:0];
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_state <= DIV_DONE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/pwm_duty_meter.sv
// Oversampling PWM duty meter: synchronizer, rise detect, IDLE/ARM/MEASURE counters,
// serial divider and output registers. Define DUTY_METER_AVG_EN for IIR-averaged duty.
module pwm_duty_meter
  import duty_meter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DUTY_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  pwm_duty_meter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   w_sync, w_rise;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.pwm_in};
      r_sync_d <= w_sync;
    end
  end

  meter_state_e      r_state;
  logic [CNT_W-1:0]  r_hi, r_per, r_snap_per, r_period;
  logic [DUTY_W-1:0] r_duty;
  logic              r_overflow, r_overrun, r_valid;
  logic              w_start, w_div_busy, w_div_done;
  logic [DUTY_W-1:0] w_div_quot, w_duty_code;

  assign w_start = bus.en && (r_state == MEASURE) && w_rise && !w_div_busy;

  duty_divider #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_abort (!bus.en),
    .i_num   (r_hi),
    .i_den   (r_per),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quot  (w_div_quot)
  );

  // The rise cycle is counted as cycle 1 of the new period (and as a high cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_hi       <= '0;
      r_per      <= '0;
      r_overflow <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (!bus.en) begin
        r_state   <= IDLE;
        r_hi      <= '0;
        r_per     <= '0;
        r_overrun <= 1'b0;
      end else begin
        case (r_state)
          IDLE: r_state <= ARM;
          ARM: if (w_rise) begin
            r_state <= MEASURE;
            r_hi    <= CNT_W'(1);
            r_per   <= CNT_W'(1);
          end
          MEASURE: begin
            if (w_rise) begin
              r_hi  <= CNT_W'(1);
              r_per <= CNT_W'(1);
              if (w_div_busy) r_overrun <= 1'b1;
            end else if (r_per == CNT_MAX) begin
              r_overflow <= 1'b1;
              r_state    <= ARM;
              r_hi       <= '0;
              r_per      <= '0;
            end else begin
              r_per <= r_per + CNT_W'(1);
              r_hi  <= r_hi + CNT_W'(w_sync);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef DUTY_METER_AVG_EN
  localparam int AW = DUTY_W + AVG_SHIFT;
  logic [AW-1:0]   r_avg;
  logic            r_avg_first;
  logic signed [AW:0] w_diff;
  logic [AW-1:0]   w_avg_upd;

  assign w_diff      = $signed({1'b0, w_div_quot, {AVG_SHIFT{1'b0}}}) - $signed({1'b0, r_avg});
  assign w_avg_upd   = r_avg_first ? {w_div_quot, {AVG_SHIFT{1'b0}}}
                                   : AW'($signed({1'b0, r_avg}) + (w_diff >>> AVG_SHIFT));
  assign w_duty_code = w_avg_upd[AW-1:AVG_SHIFT];

  // The first result after IDLE/reset seeds the average instead of blending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_avg       <= '0;
      r_avg_first <= 1'b1;
    end else if (!bus.en) begin
      r_avg_first <= 1'b1;
    end else if (w_div_done) begin
      r_avg       <= w_avg_upd;
      r_avg_first <= 1'b0;
    end
  end
`else
  assign w_duty_code = w_div_quot;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_per <= '0;
      r_period   <= '0;
      r_duty     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_start) r_snap_per <= r_per;
      if (bus.en && w_div_done) begin
        r_valid  <= 1'b1;
        r_duty   <= w_duty_code;
        r_period <= r_snap_per;
      end
    end
  end

  assign bus.duty_out   = r_duty;
  assign bus.period_out = r_period;
  assign bus.duty_valid = r_valid;
  assign bus.overflow   = r_overflow;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: drives PWM waveforms and checks each duty_valid event
// (cycle, duty, period) against a model built from the recorded rise times.
module tb_pwm_duty_meter;
  localparam int CNT_W = 16, DUTY_W = 10, SYNC = 2;
  localparam int LAT = SYNC + DUTY_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pwm_duty_meter_if #(.CNT_W(CNT_W), .DUTY_W(DUTY_W)) bus();

  pwm_duty_meter #(.CNT_W(CNT_W), .DUTY_W(DUTY_W), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int rq[$], hq[$];
  int ev_c[$], ev_d[$], ev_p[$], ovf_c[$];
  int exp_c[$], exp_d[$], exp_p[$];
  bit exp_ovr;
  bit avg_first = 1'b1;
  int avg = 0;

  always @(negedge clk) begin
    if (bus.duty_valid === 1'b1) begin
      ev_c.push_back(cyc); ev_d.push_back(int'(bus.duty_out)); ev_p.push_back(int'(bus.period_out));
    end
    if (bus.overflow === 1'b1) ovf_c.push_back(cyc);
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    rq.delete(); hq.delete(); ev_c.delete(); ev_d.delete(); ev_p.delete(); ovf_c.delete();
  endtask

  task automatic restart();
    bus.en = 1'b0; bus.pwm_in = 1'b0;
    tick(3);
    bus.en = 1'b1;
    avg_first = 1'b1;
    tick(4);
    clear_q();
  endtask

  // one PWM period: hi cycles high, then low for the rest
  task automatic pwm_period(input int hi, input int p);
    rq.push_back(cyc); hq.push_back(hi);
    bus.pwm_in = 1'b1; tick(hi);
    bus.pwm_in = 1'b0; tick(p - hi);
  endtask

  // closing rise that ends the last period, then wait out the division
  task automatic fin();
    rq.push_back(cyc); hq.push_back(1);
    bus.pwm_in = 1'b1; tick(1);
    bus.pwm_in = 1'b0; tick(LAT + 4);
  endtask

  // Reference: first rise arms; each later rise ends a period that is reported
  // DUTY_W+1 cycles after detection unless the previous report is still in flight.
  task automatic build_expected();
    int last;
    exp_c.delete(); exp_d.delete(); exp_p.delete();
    exp_ovr = 1'b0;
    last = -100000;
    for (int i = 1; i < rq.size(); i++) begin
      int det, p, q;
      det = rq[i] + SYNC;
      p   = rq[i] - rq[i-1];
      if (det <= last + DUTY_W + 1) begin
        exp_ovr = 1'b1;
        continue;
      end
      q = (hq[i-1] * (1 << DUTY_W)) / p;
      if (q > (1 << DUTY_W) - 1) q = (1 << DUTY_W) - 1;
`ifdef DUTY_METER_AVG_EN
      if (avg_first) avg = q * 8;
      else avg = avg + ((q * 8 - avg) >>> 3);
      avg_first = 1'b0;
      q = avg >>> 3;
`endif
      exp_c.push_back(det + DUTY_W + 1); exp_d.push_back(q); exp_p.push_back(p);
      last = det;
    end
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.pwm_in = 1'b0; rst_n = 1'b0;
    tick(3);
    if (bus.duty_out !== '0) begin errors++; $display("FAIL reset_duty: got %0d want 0", bus.duty_out); end
    checks++;
    if (bus.period_out !== '0) begin errors++; $display("FAIL reset_period: got %0d want 0", bus.period_out); end
    checks++;
    if (bus.duty_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.duty_valid); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    checks++;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic();
    restart();
    repeat (4) pwm_period(5, 20);
    fin();
    build_expected();
    if (ev_c.size() !== exp_c.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", ev_c.size(), exp_c.size()); end
    checks++;
    foreach (exp_c[i]) if (i < ev_c.size()) begin
      if (ev_c[i] !== exp_c[i] || ev_d[i] !== exp_d[i] || ev_p[i] !== exp_p[i]) begin
        errors++; $display("FAIL basic_ev%0d: got cyc %0d duty %0d per %0d want cyc %0d duty %0d per %0d",
                           i, ev_c[i], ev_d[i], ev_p[i], exp_c[i], exp_d[i], exp_p[i]);
      end
      checks++;
    end
    if (bus.duty_out !== 10'd256) begin errors++; $display("FAIL basic_duty256: got %0d want 256", bus.duty_out); end
    checks++;
    if (bus.period_out !== 16'd20) begin errors++; $display("FAIL basic_period20: got %0d want 20", bus.period_out); end
    checks++;
  endtask

  task automatic test_step();
    restart();
    repeat (3) pwm_period(10, 20);
    repeat (3) pwm_period(15, 20);
    fin();
    build_expected();
    if (ev_c.size() !== exp_c.size()) begin errors++; $display("FAIL step_count: got %0d want %0d", ev_c.size(), exp_c.size()); end
    checks++;
    foreach (exp_c[i]) if (i < ev_c.size()) begin
      if (ev_c[i] !== exp_c[i] || ev_d[i] !== exp_d[i] || ev_p[i] !== exp_p[i]) begin
        errors++; $display("FAIL step_ev%0d: got cyc %0d duty %0d per %0d want cyc %0d duty %0d per %0d",
                           i, ev_c[i], ev_d[i], ev_p[i], exp_c[i], exp_d[i], exp_p[i]);
      end
      checks++;
    end
`ifndef DUTY_METER_AVG_EN
    if (bus.duty_out !== 10'd768) begin errors++; $display("FAIL step_duty768: got %0d want 768", bus.duty_out); end
    checks++;
`endif
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      restart();
      for (int k = 0; k < 14; k++) begin
        int p, h;
        p = (r == 0) ? int'($urandom_range(DUTY_W + 2, 60)) : int'($urandom_range(2, 30));
        h = int'($urandom_range(1, p - 1));
        pwm_period(h, p);
      end
      fin();
      build_expected();
      if (ev_c.size() !== exp_c.size()) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", r, ev_c.size(), exp_c.size()); end
      checks++;
      foreach (exp_c[i]) if (i < ev_c.size()) begin
        if (ev_c[i] !== exp_c[i] || ev_d[i] !== exp_d[i] || ev_p[i] !== exp_p[i]) begin
          errors++; $display("FAIL rand%0d_ev%0d: got cyc %0d duty %0d per %0d want cyc %0d duty %0d per %0d",
                             r, i, ev_c[i], ev_d[i], ev_p[i], exp_c[i], exp_d[i], exp_p[i]);
        end
        checks++;
      end
      if (bus.overrun !== exp_ovr) begin errors++; $display("FAIL rand%0d_overrun: got %b want %b", r, bus.overrun, exp_ovr); end
      checks++;
    end
  endtask

  task automatic test_overrun();
    restart();
    repeat (6) pwm_period(4, 8);
    fin();
    build_expected();
    if (ev_c.size() !== exp_c.size()) begin errors++; $display("FAIL ovr_count: got %0d want %0d", ev_c.size(), exp_c.size()); end
    checks++;
    foreach (exp_c[i]) if (i < ev_c.size()) begin
      if (ev_c[i] !== exp_c[i] || ev_d[i] !== exp_d[i] || ev_p[i] !== exp_p[i]) begin
        errors++; $display("FAIL ovr_ev%0d: got cyc %0d duty %0d per %0d want cyc %0d duty %0d per %0d",
                           i, ev_c[i], ev_d[i], ev_p[i], exp_c[i], exp_d[i], exp_p[i]);
      end
      checks++;
    end
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    checks++;
    bus.en = 1'b0; tick(1); bus.en = 1'b1;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", bus.overrun); end
    checks++;
  endtask

  task automatic test_overflow();
    int det, held_d, held_p;
    restart();
    repeat (3) pwm_period(5, 20);
    fin();
    build_expected();
    det = rq[rq.size() - 1] + SYNC;
    held_d = int'(bus.duty_out); held_p = int'(bus.period_out);
    if (ev_c.size() !== exp_c.size()) begin errors++; $display("FAIL ovf_pre_count: got %0d want %0d", ev_c.size(), exp_c.size()); end
    checks++;
    for (int k = 0; k < 70000 && ovf_c.size() == 0; k++) tick(1);
    tick(3);
    if (ovf_c.size() !== 1) begin errors++; $display("FAIL ovf_pulses: got %0d want 1", ovf_c.size()); end
    checks++;
    if (ovf_c.size() > 0) begin
      if (ovf_c[0] < det + 65534 || ovf_c[0] > det + 65537) begin
        errors++; $display("FAIL ovf_time: got %0d cycles after rise want about 65535", ovf_c[0] - det);
      end
      checks++;
    end
    if (int'(bus.duty_out) !== held_d || int'(bus.period_out) !== held_p) begin
      errors++; $display("FAIL ovf_hold: got duty %0d per %0d want %0d %0d", bus.duty_out, bus.period_out, held_d, held_p);
    end
    checks++;
    clear_q();
    repeat (2) pwm_period(6, 20);
    fin();
    build_expected();
    if (ev_c.size() !== exp_c.size()) begin errors++; $display("FAIL ovf_rearm_count: got %0d want %0d", ev_c.size(), exp_c.size()); end
    checks++;
    foreach (exp_c[i]) if (i < ev_c.size()) begin
      if (ev_c[i] !== exp_c[i] || ev_d[i] !== exp_d[i] || ev_p[i] !== exp_p[i]) begin
        errors++; $display("FAIL ovf_rearm_ev%0d: got cyc %0d duty %0d per %0d want cyc %0d duty %0d per %0d",
                           i, ev_c[i], ev_d[i], ev_p[i], exp_c[i], exp_d[i], exp_p[i]);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    restart();
    repeat (3) pwm_period(5, 20);
    rq.push_back(cyc); hq.push_back(7);
    bus.pwm_in = 1'b1; tick(7);
    rst_n = 1'b0; #1;
    if (bus.duty_out !== '0 || bus.period_out !== '0 || bus.duty_valid !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++; $display("FAIL rstmid_zero: got duty %0d per %0d valid %b ovf %b ovr %b want all 0",
                         bus.duty_out, bus.period_out, bus.duty_valid, bus.overflow, bus.overrun);
    end
    checks++;
    tick(2);
    clear_q();
    avg_first = 1'b1;
    bus.pwm_in = 1'b0; rst_n = 1'b1;
    tick(4);
    repeat (2) pwm_period(9, 20);
    fin();
    build_expected();
    if (ev_c.size() !== exp_c.size()) begin errors++; $display("FAIL rstmid_count: got %0d want %0d", ev_c.size(), exp_c.size()); end
    checks++;
    foreach (exp_c[i]) if (i < ev_c.size()) begin
      if (ev_c[i] !== exp_c[i] || ev_d[i] !== exp_d[i] || ev_p[i] !== exp_p[i]) begin
        errors++; $display("FAIL rstmid_ev%0d: got cyc %0d duty %0d per %0d want cyc %0d duty %0d per %0d",
                           i, ev_c[i], ev_d[i], ev_p[i], exp_c[i], exp_d[i], exp_p[i]);
      end
      checks++;
    end
  endtask

  task automatic test_avg_step();
    bit mono;
    restart();
    repeat (4) pwm_period(5, 20);
    repeat (60) pwm_period(15, 20);
    fin();
    build_expected();
    if (ev_c.size() !== exp_c.size()) begin errors++; $display("FAIL avg_count: got %0d want %0d", ev_c.size(), exp_c.size()); end
    checks++;
    foreach (exp_c[i]) if (i < ev_c.size()) begin
      if (ev_c[i] !== exp_c[i] || ev_d[i] !== exp_d[i] || ev_p[i] !== exp_p[i]) begin
        errors++; $display("FAIL avg_ev%0d: got cyc %0d duty %0d per %0d want cyc %0d duty %0d per %0d",
                           i, ev_c[i], ev_d[i], ev_p[i], exp_c[i], exp_d[i], exp_p[i]);
      end
      checks++;
    end
    if (ev_d.size() > 4) begin
      if (ev_d[0] !== 256) begin errors++; $display("FAIL avg_first: got %0d want 256", ev_d[0]); end
      checks++;
`ifdef DUTY_METER_AVG_EN
      mono = 1'b1;
      for (int i = 1; i < ev_d.size(); i++) if (ev_d[i] < ev_d[i-1]) mono = 1'b0;
      if (mono !== 1'b1) begin errors++; $display("FAIL avg_monotonic: got non-monotonic codes want monotonic"); end
      checks++;
      if (ev_d[ev_d.size() - 1] < 766) begin errors++; $display("FAIL avg_settle: got %0d want >=766", ev_d[ev_d.size() - 1]); end
      checks++;
`else
      mono = 1'b0;
      if (ev_d[4] !== 768) begin errors++; $display("FAIL avg_immediate: got %0d want 768", ev_d[4]); end
      checks++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step();
    test_random();
    test_overrun();
    test_reset_mid();
    test_avg_step();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
